// File: rtl/l2_refill_arbiter.sv
// l2_refill_arbiter
// Shares the single L2 line-refill port between the I$ and D$ miss paths.
// One refill is in flight at a time. Requesters are picked round-robin,
// the line-aligned address goes to L2, the returned line is buffered, and
// the line is handed back to the cache that owns the transaction.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   ic_req_* / dc_req_*       L1 refill requests (valid/addr in, ready out)
//   ic_resp_* / dc_resp_*     refill line back to each L1 (valid/data out, ready in)
//   l2_req_*                  line-aligned request to L2 (valid/addr out, ready in)
//   l2_resp_*                 line return from L2 (valid/data in, ready out)
//   busy_o                    a transaction is in flight
//   owner_o                   current/last owner: 0 = I$, 1 = D$
module l2_refill_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ic_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]  ic_req_addr_i,
  output logic                   ic_req_ready_o,
  output logic                   ic_resp_valid_o,
  output logic [LINE_SIZE*8-1:0] ic_resp_data_o,
  input  logic                   ic_resp_ready_i,
  input  logic                   dc_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]  dc_req_addr_i,
  output logic                   dc_req_ready_o,
  output logic                   dc_resp_valid_o,
  output logic [LINE_SIZE*8-1:0] dc_resp_data_o,
  input  logic                   dc_resp_ready_i,
  output logic                   l2_req_valid_o,
  output logic [ADDR_WIDTH-1:0]  l2_req_addr_o,
  input  logic                   l2_req_ready_i,
  input  logic                   l2_resp_valid_i,
  input  logic [LINE_SIZE*8-1:0] l2_resp_data_i,
  output logic                   l2_resp_ready_o,
  output logic                   busy_o,
  output logic                   owner_o
);

  localparam int OFFSET = $clog2(LINE_SIZE);
  localparam int DATA_W = LINE_SIZE * 8;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFSET;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    L2_REQ  = 2'd1,
    L2_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state, state_next;
  logic owner, last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_W-1:0] line_q;
  logic ic_win, dc_win, owner_ready;

  // Round-robin pick. With both valid the one that did not win last time
  // goes first. Nothing is granted during a reset cycle so no requester
  // believes it was accepted by a transaction that reset is about to drop.
  always_comb begin
    ic_win = 1'b0;
    dc_win = 1'b0;
    if (state == ARB && !rst_i) begin
      if (ic_req_valid_i && dc_req_valid_i) begin
        ic_win = last_grant;
        dc_win = !last_grant;
      end else begin
        ic_win = ic_req_valid_i;
        dc_win = dc_req_valid_i;
      end
    end
  end

  assign owner_ready = owner ? dc_resp_ready_i : ic_resp_ready_i;

  // Next-state and handshake outputs. Response data is only driven to the
  // owning cache while its valid is up.
  always_comb begin
    state_next      = state;
    ic_req_ready_o  = ic_win;
    dc_req_ready_o  = dc_win;
    l2_req_valid_o  = 1'b0;
    l2_resp_ready_o = 1'b0;
    ic_resp_valid_o = 1'b0;
    dc_resp_valid_o = 1'b0;
    ic_resp_data_o  = '0;
    dc_resp_data_o  = '0;
    case (state)
      ARB: begin
        if (ic_win || dc_win) state_next = L2_REQ;
      end
      L2_REQ: begin
        l2_req_valid_o = 1'b1;
        if (l2_req_ready_i) state_next = L2_WAIT;
      end
      L2_WAIT: begin
        l2_resp_ready_o = 1'b1;
        if (l2_resp_valid_i) state_next = RESP;
      end
      RESP: begin
        if (owner) begin
          dc_resp_valid_o = 1'b1;
          dc_resp_data_o  = line_q;
        end else begin
          ic_resp_valid_o = 1'b1;
          ic_resp_data_o  = line_q;
        end
        if (owner_ready) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  assign l2_req_addr_o = addr_q;
  assign busy_o        = (state != ARB);
  assign owner_o       = owner;

  // State, transaction context and line buffer. last_grant resets to D$
  // so the I$ wins the first tie after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ARB;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      line_q     <= '0;
    end else begin
      state <= state_next;
      if (ic_win || dc_win) begin
        owner  <= dc_win;
        addr_q <= (dc_win ? dc_req_addr_i : ic_req_addr_i) & LINE_MASK;
      end
      if (state == L2_WAIT && l2_resp_valid_i) line_q <= l2_resp_data_i;
      if (state == RESP && owner_ready) last_grant <= owner;
    end
  end

endmodule

// File: tb/tb_l2_refill_arbiter.sv
// tb_l2_refill_arbiter
// Directed scenarios with literal expectations followed by a long random
// run; a transaction-level model of the arbiter predicts every output on
// every cycle and a single compare process checks the DUT against it.
module tb_l2_refill_arbiter;

  localparam int AW = 32;
  localparam int LS = 64;
  localparam int DW = LS * 8;

  logic clk;
  logic rst_i;
  logic ic_req_valid_i, dc_req_valid_i;
  logic [AW-1:0] ic_req_addr_i, dc_req_addr_i;
  logic ic_req_ready_o, dc_req_ready_o;
  logic ic_resp_valid_o, dc_resp_valid_o;
  logic [DW-1:0] ic_resp_data_o, dc_resp_data_o;
  logic ic_resp_ready_i, dc_resp_ready_i;
  logic l2_req_valid_o;
  logic [AW-1:0] l2_req_addr_o;
  logic l2_req_ready_i;
  logic l2_resp_valid_i;
  logic [DW-1:0] l2_resp_data_i;
  logic l2_resp_ready_o;
  logic busy_o, owner_o;

  l2_refill_arbiter #(.ADDR_WIDTH(AW), .LINE_SIZE(LS)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i),
    .ic_req_ready_o(ic_req_ready_o), .ic_resp_valid_o(ic_resp_valid_o),
    .ic_resp_data_o(ic_resp_data_o), .ic_resp_ready_i(ic_resp_ready_i),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_addr_i(dc_req_addr_i),
    .dc_req_ready_o(dc_req_ready_o), .dc_resp_valid_o(dc_resp_valid_o),
    .dc_resp_data_o(dc_resp_data_o), .dc_resp_ready_i(dc_resp_ready_i),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_addr_o(l2_req_addr_o),
    .l2_req_ready_i(l2_req_ready_i), .l2_resp_valid_i(l2_resp_valid_i),
    .l2_resp_data_i(l2_resp_data_i), .l2_resp_ready_o(l2_resp_ready_o),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Transaction-level model: is a refill pending, who owns it, has L2
  // taken the address, has the line come back, and who was served last.
  bit m_pending, m_owner, m_addr_taken, m_line_back, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_line;
  bit cmp_en = 0;
  bit ic_acc, dc_acc;
  bit a_ic, a_dc;
  bit ic_hold, dc_hold;

  task automatic check_output(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ic_ready();
    return !rst_i && !m_pending && ic_req_valid_i && (!dc_req_valid_i || m_last);
  endfunction

  function automatic bit exp_dc_ready();
    return !rst_i && !m_pending && dc_req_valid_i && (!ic_req_valid_i || !m_last);
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Advance the model on each rising edge from the inputs present there.
  always @(posedge clk) begin
    a_ic = exp_ic_ready();
    a_dc = exp_dc_ready();
    ic_acc = a_ic;
    dc_acc = a_dc;
    if (rst_i) begin
      m_pending = 0; m_owner = 0; m_addr_taken = 0; m_line_back = 0;
      m_last = 1; m_addr = '0; m_line = '0;
      cmp_en = 1;
    end else if (!m_pending) begin
      if (a_ic || a_dc) begin
        m_pending = 1;
        m_owner = a_dc;
        m_addr = a_dc ? dc_req_addr_i : ic_req_addr_i;
        m_addr = m_addr - (m_addr % LS);
        m_addr_taken = 0;
        m_line_back = 0;
      end
    end else if (!m_addr_taken) begin
      m_addr_taken = l2_req_ready_i;
    end else if (!m_line_back) begin
      if (l2_resp_valid_i) begin
        m_line_back = 1;
        m_line = l2_resp_data_i;
      end
    end else if (m_owner ? dc_resp_ready_i : ic_resp_ready_i) begin
      m_pending = 0;
      m_last = m_owner;
    end
  end

  // Compare every DUT output with the model between clock edges.
  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      check_output("m_ic_req_ready", ic_req_ready_o, exp_ic_ready());
      check_output("m_dc_req_ready", dc_req_ready_o, exp_dc_ready());
      check_output("m_l2_req_valid", l2_req_valid_o, m_pending && !m_addr_taken);
      check_output("m_l2_resp_ready", l2_resp_ready_o,
                   m_pending && m_addr_taken && !m_line_back);
      check_output("m_ic_resp_valid", ic_resp_valid_o, m_pending && m_line_back && !m_owner);
      check_output("m_dc_resp_valid", dc_resp_valid_o, m_pending && m_line_back && m_owner);
      check_output("m_busy", busy_o, m_pending);
      check_output("m_owner", owner_o, m_owner);
      if (m_pending && !m_addr_taken) check_output("m_l2_req_addr", l2_req_addr_o, m_addr);
      if (m_pending && m_line_back && !m_owner)
        check_output("m_ic_resp_data", ic_resp_data_o, m_line);
      if (m_pending && m_line_back && m_owner)
        check_output("m_dc_resp_data", dc_resp_data_o, m_line);
    end
  end

  task automatic idle_inputs();
    ic_req_valid_i = 0; dc_req_valid_i = 0;
    ic_req_addr_i = '0; dc_req_addr_i = '0;
    ic_resp_ready_i = 0; dc_resp_ready_i = 0;
    l2_req_ready_i = 0; l2_resp_valid_i = 0; l2_resp_data_i = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    ic_hold = 0;
    dc_hold = 0;

    // Single I$ refill at minimum latency.
    apply_reset();
    ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_1234;
    #3 check_output("t1_ic_ready", ic_req_ready_o, 1);
    check_output("t1_dc_ready", dc_req_ready_o, 0);
    @(negedge clk);
    ic_req_valid_i = 0; l2_req_ready_i = 1;
    #3 check_output("t1_l2_valid", l2_req_valid_o, 1);
    check_output("t1_l2_addr", l2_req_addr_o, 32'h0000_1200);
    @(negedge clk);
    l2_req_ready_i = 0; l2_resp_valid_i = 1; l2_resp_data_i = {LS{8'hA5}}; ic_resp_ready_i = 1;
    #3 check_output("t1_l2_resp_ready", l2_resp_ready_o, 1);
    @(negedge clk);
    l2_resp_valid_i = 0;
    #3 check_output("t1_ic_resp_valid", ic_resp_valid_o, 1);
    check_output("t1_ic_resp_data", ic_resp_data_o, {LS{8'hA5}});
    check_output("t1_dc_resp_valid", dc_resp_valid_o, 0);
    @(negedge clk);
    ic_resp_ready_i = 0;
    #3 check_output("t1_busy_done", busy_o, 0);

    // Both requesters continuously valid: grants alternate starting with I$.
    apply_reset();
    ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_0100;
    dc_req_valid_i = 1; dc_req_addr_i = 32'h0000_2040;
    l2_req_ready_i = 1; l2_resp_valid_i = 1; l2_resp_data_i = {LS{8'h11}};
    ic_resp_ready_i = 1; dc_resp_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      #3 check_output("t2_ic_grant", ic_req_ready_o, (k % 2) == 0);
      check_output("t2_dc_grant", dc_req_ready_o, (k % 2) == 1);
      @(negedge clk);
      #3 check_output("t2_owner", owner_o, (k % 2) == 1);
      repeat (3) @(negedge clk);
    end

    // L2 stalls the request; a stray L2 response must be ignored.
    apply_reset();
    dc_req_valid_i = 1; dc_req_addr_i = 32'hDEAD_BEEF;
    #3 check_output("t3_dc_ready", dc_req_ready_o, 1);
    @(negedge clk);
    dc_req_valid_i = 0; ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_4444;
    for (int c = 0; c < 5; c++) begin
      l2_resp_valid_i = (c == 2);
      l2_resp_data_i = {LS{8'h55}};
      #3 check_output("t3_l2_valid_hold", l2_req_valid_o, 1);
      check_output("t3_l2_addr_hold", l2_req_addr_o, 32'hDEAD_BEC0);
      check_output("t3_ic_not_ready", ic_req_ready_o, 0);
      @(negedge clk);
    end
    l2_resp_valid_i = 0; l2_req_ready_i = 1;
    @(negedge clk);
    l2_req_ready_i = 0; l2_resp_valid_i = 1; l2_resp_data_i = {LS{8'h3C}};
    #3 check_output("t3_l2_resp_ready", l2_resp_ready_o, 1);
    check_output("t3_l2_valid_off", l2_req_valid_o, 0);
    @(negedge clk);
    l2_resp_valid_i = 0;
    for (int c = 0; c < 3; c++) begin
      #3 check_output("t4_dc_resp_hold", dc_resp_valid_o, 1);
      check_output("t4_dc_data_hold", dc_resp_data_o, {LS{8'h3C}});
      check_output("t4_ic_resp_valid", ic_resp_valid_o, 0);
      check_output("t4_ic_blocked", ic_req_ready_o, 0);
      @(negedge clk);
    end
    dc_resp_ready_i = 1;
    #3 check_output("t4_ic_blocked_last", ic_req_ready_o, 0);
    @(negedge clk);
    dc_resp_ready_i = 0;
    #3 check_output("t4_ic_accepted", ic_req_ready_o, 1);
    @(negedge clk);
    ic_req_valid_i = 0; l2_req_ready_i = 1;
    @(negedge clk);
    l2_req_ready_i = 0; l2_resp_valid_i = 1; ic_resp_ready_i = 1;
    @(negedge clk);
    l2_resp_valid_i = 0;
    @(negedge clk);
    ic_resp_ready_i = 0;

    // I$ was served last; reset in L2_WAIT of a D$ refill must restore I$ priority.
    dc_req_valid_i = 1; dc_req_addr_i = 32'h0000_8000;
    #3 check_output("t5_dc_ready", dc_req_ready_o, 1);
    @(negedge clk);
    dc_req_valid_i = 0; l2_req_ready_i = 1;
    @(negedge clk);
    l2_req_ready_i = 0;
    #3 check_output("t5_in_wait", l2_resp_ready_o, 1);
    rst_i = 1; l2_resp_valid_i = 1; l2_resp_data_i = {LS{8'h77}};
    @(negedge clk);
    rst_i = 0; l2_resp_valid_i = 0;
    #3 check_output("t5_busy", busy_o, 0);
    check_output("t5_l2_resp_ready", l2_resp_ready_o, 0);
    check_output("t5_l2_req_valid", l2_req_valid_o, 0);
    check_output("t5_l2_req_addr", l2_req_addr_o, 0);
    check_output("t5_dc_resp_valid", dc_resp_valid_o, 0);
    check_output("t5_ic_resp_valid", ic_resp_valid_o, 0);
    check_output("t5_owner", owner_o, 0);
    @(negedge clk);
    ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_0040;
    dc_req_valid_i = 1; dc_req_addr_i = 32'h0000_0080;
    #3 check_output("t5_ic_first", ic_req_ready_o, 1);
    check_output("t5_dc_second", dc_req_ready_o, 0);

    // Random traffic with occasional resets; requesters hold until accepted.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (ic_acc) ic_hold = 0;
      if (dc_acc) dc_hold = 0;
      if (!ic_hold && $urandom_range(0, 2) == 0) begin
        ic_hold = 1;
        ic_req_addr_i = $urandom();
      end
      if (!dc_hold && $urandom_range(0, 2) == 0) begin
        dc_hold = 1;
        dc_req_addr_i = $urandom();
      end
      ic_req_valid_i = ic_hold;
      dc_req_valid_i = dc_hold;
      l2_req_ready_i = $urandom_range(0, 1);
      l2_resp_valid_i = ($urandom_range(0, 2) == 0);
      l2_resp_data_i = rand_line();
      ic_resp_ready_i = $urandom_range(0, 1);
      dc_resp_ready_i = $urandom_range(0, 1);
      rst_i = ($urandom_range(0, 150) == 0);
    end
    @(negedge clk);
    rst_i = 0;
    idle_inputs();
    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_refill_arbiter.md
Name: l2_refill_arbiter

Overview:
Shares the single L2 line-refill port between the I$ and the D$ miss paths.
- Accepts one line-refill request at a time from either L1 and grants by round-robin.
- Issues the line-aligned address to L2, buffers the returned line, and routes it back to the requester that owns the transaction.
- Sits between the L1 caches' miss/fetch logic and the L2$ request/response interface.

Parameters:
ADDR_WIDTH, 32, physical address width
LINE_SIZE, 64, cache line size in bytes; line data width is LINE_SIZE*8
OFFSET (localparam), $clog2(LINE_SIZE), line-offset bits cleared on forwarded addresses

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
ic_req_valid_i  in  1  I$ refill request
ic_req_addr_i  in  ADDR_WIDTH  I$ miss physical address
ic_req_ready_o  out  1  I$ request accepted this cycle
ic_resp_valid_o  out  1  refill line valid for I$
ic_resp_data_o  out  LINE_SIZE*8  refill line to I$
ic_resp_ready_i  in  1  I$ accepts line
dc_req_valid_i  in  1  D$ refill request
dc_req_addr_i  in  ADDR_WIDTH  D$ miss physical address
dc_req_ready_o  out  1  D$ request accepted this cycle
dc_resp_valid_o  out  1  refill line valid for D$
dc_resp_data_o  out  LINE_SIZE*8  refill line to D$
dc_resp_ready_i  in  1  D$ accepts line
l2_req_valid_o  out  1  request to L2
l2_req_addr_o  out  ADDR_WIDTH  line-aligned address to L2
l2_req_ready_i  in  1  L2 accepts request
l2_resp_valid_i  in  1  L2 line return
l2_resp_data_i  in  LINE_SIZE*8  L2 line data
l2_resp_ready_o  out  1  arbiter accepts L2 line
busy_o  out  1  transaction in flight (state != ARB)
owner_o  out  1  current/last owner: 0 = I$, 1 = D$

Behaviour:
- One clock domain, clk_i. Reset is synchronous and active-high (rst_i); it is sampled only on the rising edge of clk_i.
- Reset state: state = ARB, all outputs 0, line buffer cleared, last_grant = 1 (D$), so I$ wins the first tie.
- FSM states: ARB, L2_REQ, L2_WAIT, RESP.
- ARB:
  - If exactly one requester is valid, grant it. If both are valid, grant the one not equal to last_grant.
  - The winner's req_ready_o is asserted combinationally in the same cycle; the loser's is 0.
  - On grant: latch owner, latch addr with bits [OFFSET-1:0] forced to 0, then go to L2_REQ.
  - No valid requester: stay in ARB.
- L2_REQ:
  - l2_req_valid_o = 1 with the registered address, both held stable until l2_req_ready_i.
  - On l2_req_ready_i: go to L2_WAIT.
- L2_WAIT:
  - l2_resp_ready_o = 1.
  - On l2_resp_valid_i: capture l2_resp_data_i into the line buffer, then go to RESP.
- RESP:
  - Owner's resp_valid_o = 1 with the buffered line; the other requester's resp_valid_o = 0.
  - Data is held stable until the owner's resp_ready_i. Then set last_grant = owner and go to ARB.
- Minimum latency, with L2 ready and responding immediately:
  - grant at cycle 0
  - l2_req_valid_o at cycle 1
  - resp captured at cycle 2
  - resp_valid_o at cycle 3
  - next grant possible at cycle 4 if resp_ready_i is high at cycle 3.
- l2_resp_valid_i outside L2_WAIT is ignored; buffer and state are unchanged.
- l2_resp_ready_o is 0 in every state except L2_WAIT.
- Requests arriving while busy are not accepted (req_ready_o = 0); requesters must hold valid and address until ready.
- Only one transaction is outstanding; there is no reordering or pipelining.
- Unmasked req_addr offset bits never reach L2.
- rst_i mid-transaction, in any state: next cycle the FSM is in ARB and all outputs are 0. The in-flight L2 response, if any, is dropped.
- Illegal or unused state encoding: return to ARB.

Test Plan:
- Reset then ic_req_valid_i=1, ic_req_addr_i=0x0000_1234 -> ic_req_ready_o=1 in the same cycle; next cycle l2_req_valid_o=1 with l2_req_addr_o=0x0000_1200.
- L2 returns data 0xA5..A5 at cycle 2 with ic_resp_ready_i=1 -> ic_resp_valid_o=1 at cycle 3 with data 0xA5..A5; dc_resp_valid_o=0; busy_o=0 at cycle 4.
- Both requesters valid continuously for 4 transactions right after reset -> grant order I$, D$, I$, D$; owner_o matches each grant.
- Hold l2_req_ready_i=0 for 5 cycles -> l2_req_valid_o and l2_req_addr_o stay stable; no req_ready_o asserted; l2_resp_valid_i pulse during L2_REQ is ignored.
- D$ transaction in RESP with dc_resp_ready_i=0 for 3 cycles -> dc_resp_valid_o and data held stable; a new ic_req_valid_i is not accepted until the cycle after dc_resp_ready_i=1.
- Assert rst_i while in L2_WAIT -> next cycle state ARB, all outputs 0, l2_resp_ready_o=0; a subsequent simultaneous request grants I$ first.
